if_id_pipe_reg: RTL and testbench
=================================

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC/next-PC field width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction field width.
REQ-003 SHALL have parameter NOP_INSTR, default 0, instruction value driven when no valid entry is held.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  fetch presents an entry.
REQ-007 SHALL have port in_ready  out  1  stage can accept an entry.
REQ-008 SHALL have port pc_in  in  PC_W  PC+4 of the fetched instruction.
REQ-009 SHALL have port instr_in  in  INSTR_W  fetched instruction.
REQ-010 SHALL have port flush  in  1  discard all held entries (branch/jump redirect).
REQ-011 SHALL have port out_valid  out  1  decode-side entry valid.
REQ-012 SHALL have port out_ready  in  1  decode accepts the entry.
REQ-013 SHALL have port pc_out  out  PC_W  held PC+4.
REQ-014 SHALL have port instr_out  out  INSTR_W  held instruction, NOP_INSTR when out_valid=0.

Function
REQ-015 SHALL implement a 2-entry skid buffer: main entry drives outputs; skid entry holds one overflow entry.
REQ-016 SHALL drive in_ready = NOT skid_valid, from a register, with no combinational path from out_ready.
REQ-017 SHALL accept an upstream entry when in_valid=1 and in_ready=1 (in_fire); SHALL transfer downstream when out_valid=1 and out_ready=1 (out_fire).
REQ-018 SHALL have latency 1 cycle: an entry accepted into an empty stage appears on outputs the next cycle.
REQ-019 SHALL, on in_fire with main empty or out_fire this cycle and skid empty, load the main entry directly.
REQ-020 SHALL, on in_fire with main valid and no out_fire, load the skid entry (in_ready falls next cycle).
REQ-021 SHALL, on out_fire with skid valid, move the skid entry to main and clear skid_valid in the same edge; in_ready rises next cycle.
REQ-022 SHALL preserve order: entries leave in acceptance order; no entry duplicated or lost unless flushed.
REQ-023 SHALL hold pc_out/instr_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on flush=1, clear main and skid valid at that edge and ignore in_valid that cycle; out_valid=0, in_ready=1 next cycle; flush has priority over every other event.
REQ-025 SHALL drive instr_out=NOP_INSTR and pc_out=0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force out_valid=0, skid_valid=0, in_ready=1, pc_out=0, instr_out=NOP_INSTR, all counters 0.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; an entry held when reset asserts is lost.

Configuration
REQ-028 SHALL, with macro IF_ID_PIPE_REG_STATS_EN defined, add outputs stall_cnt[31:0] (cycles with out_valid=1, out_ready=0) and flush_cnt[31:0] (valid entries discarded by flush, +0/+1/+2 per flush), both saturating at 32'hFFFF_FFFF.
REQ-029 SHALL, without IF_ID_PIPE_REG_STATS_EN, omit those ports and counters entirely; datapath behaviour identical.

Verification
REQ-030 Reset: rst_n=0 mid-traffic -> out_valid=0, in_ready=1, instr_out=NOP_INSTR immediately, without waiting for clk.
REQ-031 Stream: out_ready=1, entries (pc 0x4, 0x8C000000), (pc 0x8, 0x00221820) on consecutive cycles -> each appears one cycle later, in order, in_ready stays 1.
REQ-032 Backpressure: out_ready=0, push A then B -> out shows A, in_ready=0 after B; raise out_ready -> A, then B, in_ready=1 one cycle after B moves to main.
REQ-033 Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, new input dropped; with stats, flush_cnt increments by 2.
REQ-034 Simultaneous: main valid, out_fire and in_fire same cycle, skid empty -> new entry in main, skid stays empty, no bubble.
REQ-035 Stats saturation: stall_cnt preloaded via forced stall near 32'hFFFF_FFFE, 3 stall cycles -> reads 32'hFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: a 2-entry skid buffer between fetch and decode.
// Define IF_ID_PIPE_REG_STATS_EN to add the stall_cnt/flush_cnt statistics outputs.
module if_id_pipe_reg #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instr_out
`ifdef IF_ID_PIPE_REG_STATS_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // a producer holds valid and its payload until that edge, and ready never waits on valid.
   logic               main_valid;
   logic [PC_W-1:0]    main_pc;
   logic [INSTR_W-1:0] main_instr;
   logic               skid_valid;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               in_fire;
   logic               out_fire;

   // in_ready comes straight from the skid register, so out_ready never reaches it.
   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;
   assign pc_out    = main_valid ? main_pc : '0;
   assign instr_out = main_valid ? main_instr : NOP_INSTR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_instr <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         // skid full means in_ready=0, so only the drain into main can happen
         if (out_fire) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
            skid_valid <= 1'b0;
         end
      end else if (in_fire && (!main_valid || out_fire)) begin
         main_valid <= 1'b1;
         main_pc    <= pc_in;
         main_instr <= instr_in;
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_pc    <= pc_in;
         skid_instr <= instr_in;
      end else if (out_fire) begin
         main_valid <= 1'b0;
      end
   end

`ifdef IF_ID_PIPE_REG_STATS_EN
   logic [32:0] stall_sum;
   logic [32:0] flush_sum;

   assign stall_sum = {1'b0, stall_cnt} + 33'd1;
   assign flush_sum = {1'b0, flush_cnt} + 33'(main_valid) + 33'(skid_valid);

   // Both counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (main_valid && !out_ready)
            stall_cnt <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
         if (flush)
            flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed + random bench for if_id_pipe_reg with a queue model of the held entries.
// Build with IF_ID_PIPE_REG_STATS_EN defined to also check the statistics counters.
`timescale 1ns/1ps
module tb_if_id_pipe_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
`ifdef IF_ID_PIPE_REG_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] exp_stall;
   logic [31:0] exp_flush;
`endif

   logic [63:0] exp_q[$];
   int          total;
   int          bad;

   if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc_in     (pc_in),
      .instr_in  (instr_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pc_out    (pc_out),
      .instr_out (instr_out)
`ifdef IF_ID_PIPE_REG_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
`ifdef IF_ID_PIPE_REG_STATS_EN
      exp_stall = '0;
      exp_flush = '0;
`endif
   endtask

   task automatic check_outs(input string tag);
      logic        v;
      logic [63:0] head;
      v    = (exp_q.size() > 0);
      head = v ? exp_q[0] : {32'h0, NOP};
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_q.size() < 2));
      chk({tag, ".pc_out"},    64'(pc_out),    64'(head[63:32]));
      chk({tag, ".instr_out"}, 64'(instr_out), 64'(head[31:0]));
`ifdef IF_ID_PIPE_REG_STATS_EN
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
      chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(exp_flush));
`endif
   endtask

   // Model update at the edge, from the values the bench drove.
   task automatic model_edge();
      int sz;
      sz = exp_q.size();
`ifdef IF_ID_PIPE_REG_STATS_EN
      if (sz > 0 && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
      if (flush) begin
         if ({1'b0, exp_flush} + 33'(sz) > 33'h0_FFFF_FFFF) exp_flush = 32'hFFFF_FFFF;
         else exp_flush = exp_flush + 32'(sz);
      end
`endif
      if (flush) begin
         exp_q.delete();
      end else begin
         if (sz > 0 && out_ready) void'(exp_q.pop_front());
         if (in_valid && sz < 2) exp_q.push_back({pc_in, instr_in});
      end
   endtask

   // driver: check outputs at the falling edge, drive, then let the rising edge act
   task automatic cyc(input string tag, input logic iv, input logic [31:0] p, input logic [31:0] ins,
                      input logic ordy, input logic fl);
      @(negedge clk);
      check_outs(tag);
      in_valid  = iv;
      pc_in     = p;
      instr_in  = ins;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      pc_in     = '0;
      instr_in  = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      model_reset();
      #1;
      check_outs("reset_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // streaming with out_ready held high
      cyc("stream0", 1'b1, 32'h4, 32'h8C00_0000, 1'b1, 1'b0);
      cyc("stream1", 1'b1, 32'h8, 32'h0022_1820, 1'b1, 1'b0);
      cyc("stream2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc("stream3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // backpressure: A then B fill both entries, C is refused
      cyc("bp_a",     1'b1, 32'h100, 32'hAAAA_0001, 1'b0, 1'b0);
      cyc("bp_b",     1'b1, 32'h104, 32'hBBBB_0002, 1'b0, 1'b0);
      cyc("bp_c",     1'b1, 32'h108, 32'hCCCC_0003, 1'b0, 1'b0);
      cyc("bp_hold",  1'b0, 32'h0,   32'h0,         1'b0, 1'b0);
      cyc("bp_drain", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);
      cyc("bp_b_out", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);
      cyc("bp_empty", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);

      // flush with both entries full and a new entry offered
      cyc("fl_a",    1'b1, 32'h200, 32'h1111_1111, 1'b0, 1'b0);
      cyc("fl_b",    1'b1, 32'h204, 32'h2222_2222, 1'b0, 1'b0);
      cyc("fl_hit",  1'b1, 32'h208, 32'h3333_3333, 1'b1, 1'b1);
      cyc("fl_post", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);

      // simultaneous in_fire and out_fire with the skid empty
      cyc("sim_e", 1'b1, 32'h300, 32'hEEEE_0000, 1'b1, 1'b0);
      cyc("sim_f", 1'b1, 32'h304, 32'hFFFF_0000, 1'b1, 1'b0);
      cyc("sim_g", 1'b1, 32'h308, 32'h1234_5678, 1'b1, 1'b0);
      cyc("sim_z", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);
      cyc("sim_y", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         cyc("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end

      // reset asserted mid-traffic takes effect without a clock edge
      cyc("rst_a", 1'b1, 32'h400, 32'h4444_0000, 1'b0, 1'b0);
      cyc("rst_b", 1'b1, 32'h404, 32'h4444_0004, 1'b0, 1'b0);
      @(negedge clk);
      check_outs("rst_pre");
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      cyc("rst_resume0", 1'b1, 32'h500, 32'h5555_0000, 1'b1, 1'b0);
      cyc("rst_resume1", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);
      cyc("rst_resume2", 1'b0, 32'h0,   32'h0,         1'b1, 1'b0);

`ifdef IF_ID_PIPE_REG_STATS_EN
      // stall counter saturation from a preloaded value
      cyc("sat_load", 1'b1, 32'h600, 32'h6666_0000, 1'b0, 1'b0);
      @(negedge clk);
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      exp_stall = 32'hFFFF_FFFE;
      @(posedge clk);
      model_edge();
      cyc("sat1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc("sat2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc("sat3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc("sat4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

      @(negedge clk);
      check_outs("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
